reg_file_bypass: RTL
====================

// Module: reg_file_bypass
// PURPOSE
//  Register file that terminates the write-back interface (reg_write_en/dest/data) of the mips_16 core.
//  Serves two combinational ID-stage read ports with same-cycle write-to-read bypass.
//  Also provides a registered debug read port and a saturating write-back activity counter.
//  Sits between WB (write side) and ID/hazard logic (read side).
// PARAMETERS
//  DATA_W     16  width of each register and of all data ports
//  ADDR_W     3   register address width; NREG = 2**ADDR_W = 8
//  BYPASS_EN  1   1: a write in cycle N is visible on read ports in cycle N; 0: visible from N+1
//  CNT_W      16  width of the write-back activity counter
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       asynchronous reset, active-low
//  reg_write_en    in   1       write strobe from WB
//  reg_write_dest  in   ADDR_W  destination register
//  reg_write_data  in   DATA_W  write data
//  reg_read_addr_1 in   ADDR_W  read port 1 address (rs)
//  reg_read_data_1 out  DATA_W  read port 1 data, combinational
//  reg_read_addr_2 in   ADDR_W  read port 2 address (rt)
//  reg_read_data_2 out  DATA_W  read port 2 data, combinational
//  dbg_rd_req      in   1       debug read request
//  dbg_rd_addr     in   ADDR_W  debug read address
//  dbg_rd_valid    out  1       debug data valid, one-cycle pulse
//  dbg_rd_data     out  DATA_W  debug read data, registered
//  wb_count        out  CNT_W   count of accepted writes, saturating
//  wb_count_clr    in   1       synchronous clear of wb_count
// BEHAVIOUR
//  Reset (rst=0, asynchronous): all registers R0..R7 = 0; dbg_rd_valid = 0; dbg_rd_data = 0; wb_count = 0.
//  R0 is hard-wired to 0.
//   - Writes to dest 0 are dropped and do not increment wb_count.
//   - Reads of address 0 return 0 regardless of bypass.
//  Write: on posedge clk with reg_write_en=1 and dest!=0, R[dest] <= reg_write_data.
//  Read ports are combinational, with zero latency.
//   - BYPASS_EN=1: if reg_write_en and dest==addr!=0, the port returns reg_write_data; otherwise it returns R[addr].
//   - BYPASS_EN=0: the port always returns R[addr].
//  Both read ports may address the same register. Both return identical data, including bypass.
//  Debug port: 1-cycle latency.
//   - dbg_rd_req=1 in cycle N gives dbg_rd_valid=1 and dbg_rd_data in cycle N+1.
//   - Data is sampled through the same bypass rule as the read ports, i.e. it includes the cycle-N write.
//   - dbg_rd_valid is 0 in any cycle without a prior-cycle request.
//   - dbg_rd_data holds its last value when dbg_rd_valid=0.
//   - Back-to-back requests give back-to-back valids.
//  wb_count: +1 per accepted write (en=1, dest!=0); saturates at 2**CNT_W-1 and never wraps.
//   - wb_count_clr has priority: a clear and a write in the same cycle give 0, not 1.
//  Reset asserted mid-operation: state clears immediately.
//   - Any in-flight debug request is discarded; there is no valid after reset deasserts.
//   - No write is accepted in any cycle while rst=0.
//  X on reg_write_dest while reg_write_en=0 has no effect on state.
// STRUCTURE
//  Widths DATA_W/ADDR_W default from the shared mips_16_defs.v defines (data width 16, reg address 3).
//  The zero-register index and the counter saturation value also live there as defines.
//  One natural sub-module: reg_file_read_port (addr + bank + write bus -> bypassed, R0-masked data).
//   - Instantiated 3 times: ports 1, 2 and the debug sampler.
//  Storage is a flop array; a synthesis-inferred RAM is not permitted (async reset is required).
// TESTING
//  1. Reset, then read all 8 addrs on both ports -> all return 0x0000; wb_count=0, dbg_rd_valid=0.
//  2. Write R3=0xBEEF; same cycle read addr_1=3 -> 0xBEEF (BYPASS_EN=1). With BYPASS_EN=0 -> 0x0000, then 0xBEEF next cycle.
//  3. Write R0=0x1234, then read R0 on both ports and debug -> 0x0000; wb_count unchanged.
//  4. Write R5=0x00A5 and R7=0xFFFF on consecutive cycles, then dbg_rd_req addr=7, then addr=5 back-to-back
//     -> valid pulses on 2 consecutive cycles with data 0xFFFF, 0x00A5.
//  5. CNT_W=4: 20 writes to R1 -> wb_count saturates at 15. wb_count_clr plus a write in the same cycle -> 0.
//  6. Assert rst mid-stream with a dbg request pending -> regs 0 asynchronously, no dbg_rd_valid after release;
//     a write during reset is ignored.

Source files
------------

// File: rtl/reg_file_bypass_pkg.sv
// reg_file_bypass_pkg: shared widths and constants for the register file slice
//   DATA_W_DEF - default register/data width
//   ADDR_W_DEF - default register address width
//   REG_ZERO   - index of the hard-wired zero register
package reg_file_bypass_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;
   localparam int REG_ZERO   = 0;
endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: one combinational read port with write bypass and R0 masking
//   addr  - register address to read
//   bank  - current register contents
//   we    - write strobe
//   wdest - write destination
//   wdata - write data
//   data  - bypassed, R0-masked read data
module reg_file_read_port
   import reg_file_bypass_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] bank [2**ADDR_W],
   input  logic              we,
   input  logic [ADDR_W-1:0] wdest,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] data
);
   logic hit;
   // we is evaluated first so an X on wdest cannot leak through while idle
   assign hit  = BYPASS_EN && we && (wdest == addr);
   assign data = (addr == ADDR_W'(REG_ZERO)) ? '0 : hit ? wdata : bank[addr];
endmodule

// File: rtl/reg_file_bypass.sv
// reg_file_bypass: register file with bypassed read ports, debug read and write counter
//   clk, rst           - clock, asynchronous active-low reset
//   reg_write_*        - write-back interface
//   reg_read_addr/data - two combinational ID-stage read ports
//   dbg_rd_*           - registered debug read port, one-cycle latency
//   wb_count(_clr)     - saturating count of accepted writes, synchronous clear
module reg_file_bypass
   import reg_file_bypass_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter bit BYPASS_EN = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_write_en,
   input  logic [ADDR_W-1:0] reg_write_dest,
   input  logic [DATA_W-1:0] reg_write_data,
   input  logic [ADDR_W-1:0] reg_read_addr_1,
   output logic [DATA_W-1:0] reg_read_data_1,
   input  logic [ADDR_W-1:0] reg_read_addr_2,
   output logic [DATA_W-1:0] reg_read_data_2,
   input  logic              dbg_rd_req,
   input  logic [ADDR_W-1:0] dbg_rd_addr,
   output logic              dbg_rd_valid,
   output logic [DATA_W-1:0] dbg_rd_data,
   output logic [CNT_W-1:0]  wb_count,
   input  logic              wb_count_clr
);
   localparam int NREG = 2**ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [DATA_W-1:0] bank [NREG];
   logic [DATA_W-1:0] dbg_sample;
   logic              wr_acc;
   assign wr_acc = reg_write_en && (reg_write_dest != ADDR_W'(REG_ZERO));
   // Flop array with async reset; R0 is never written so it stays zero
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         for (int i = 0; i < NREG; i++) bank[i] <= '0;
      else if (wr_acc)
         bank[reg_write_dest] <= reg_write_data;
   reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(BYPASS_EN)) u_rd1 (
      .addr(reg_read_addr_1), .bank(bank), .we(reg_write_en),
      .wdest(reg_write_dest), .wdata(reg_write_data), .data(reg_read_data_1));
   reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(BYPASS_EN)) u_rd2 (
      .addr(reg_read_addr_2), .bank(bank), .we(reg_write_en),
      .wdest(reg_write_dest), .wdata(reg_write_data), .data(reg_read_data_2));
   // Debug sampler shares the bypass rule so it sees the same-cycle write
   reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS_EN(BYPASS_EN)) u_dbg (
      .addr(dbg_rd_addr), .bank(bank), .we(reg_write_en),
      .wdest(reg_write_dest), .wdata(reg_write_data), .data(dbg_sample));
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         dbg_rd_valid <= 1'b0;
         dbg_rd_data  <= '0;
      end else begin
         dbg_rd_valid <= dbg_rd_req;
         if (dbg_rd_req) dbg_rd_data <= dbg_sample;
      end
   // Clear wins over a same-cycle write
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         wb_count <= '0;
      else if (wb_count_clr)
         wb_count <= '0;
      else if (wr_acc && wb_count != CNT_MAX)
         wb_count <= wb_count + CNT_W'(1);
endmodule
